// File: rtl/axi_lite_master_arb.sv
// Round-robin arbiter that shares one AXI4-Lite master port between NUM_REQ requesters.
// One transaction is in flight at a time, and every AXI-side and requester-side output is registered.
module axi_lite_master_arb #(
  parameter int NUM_REQ        = 2,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 4
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_REQ-1:0]                  req,
  input  logic [NUM_REQ-1:0]                  we,
  input  logic [NUM_REQ*AXI_ADDR_WIDTH-1:0]   addr,
  input  logic [NUM_REQ*AXI_DATA_WIDTH-1:0]   wdata,
  input  logic [NUM_REQ*AXI_DATA_WIDTH/8-1:0] wstrb,
  output logic [NUM_REQ-1:0]                  done,
  output logic [AXI_DATA_WIDTH-1:0]           rdata,
  output logic                                err,
  output logic [AXI_ADDR_WIDTH-1:0]           axi_awaddr,
  output logic                                axi_awvalid,
  output logic [2:0]                          axi_awprot,
  input  logic                                axi_awready,
  output logic [AXI_DATA_WIDTH-1:0]           axi_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0]         axi_wstrb,
  output logic                                axi_wvalid,
  input  logic                                axi_wready,
  input  logic [1:0]                          axi_bresp,
  input  logic                                axi_bvalid,
  output logic                                axi_bready,
  output logic [AXI_ADDR_WIDTH-1:0]           axi_araddr,
  output logic                                axi_arvalid,
  output logic [2:0]                          axi_arprot,
  input  logic                                axi_arready,
  input  logic [AXI_DATA_WIDTH-1:0]           axi_rdata,
  input  logic [1:0]                          axi_rresp,
  input  logic                                axi_rvalid,
  output logic                                axi_rready
);

  localparam int SW = AXI_DATA_WIDTH / 8;
  localparam int IW = $clog2(NUM_REQ);

  typedef enum logic [2:0] {IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_RESP, DONE} state_t;

  state_t        state;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] owner;
  logic [IW-1:0] grant_idx;
  logic          grant_valid;
  logic          unused_resp;

  assign axi_awprot  = 3'b000;
  assign axi_arprot  = 3'b000;
  assign unused_resp = axi_bresp[0] ^ axi_rresp[0];

  // Rotating priority search: the first set request at or after rr_ptr wins.
  // NOTE: every always_comb output gets a default before any branch, so no latch can be inferred.
  always_comb begin
    logic [IW-1:0] cand;
    int            idx;
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    idx         = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = IW'(idx);
      if (!grant_valid && req[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      owner       <= '0;
      done        <= '0;
      rdata       <= '0;
      err         <= 1'b0;
      axi_awaddr  <= '0;
      axi_awvalid <= 1'b0;
      axi_wdata   <= '0;
      axi_wstrb   <= '0;
      axi_wvalid  <= 1'b0;
      axi_bready  <= 1'b0;
      axi_araddr  <= '0;
      axi_arvalid <= 1'b0;
      axi_rready  <= 1'b0;
    end else begin
      done <= '0;
      case (state)
        IDLE: begin
          if (grant_valid) begin
            owner  <= grant_idx;
            rr_ptr <= (grant_idx == IW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
            if (we[grant_idx]) begin
              axi_awaddr  <= addr[grant_idx*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
              axi_wdata   <= wdata[grant_idx*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
              axi_wstrb   <= wstrb[grant_idx*SW +: SW];
              axi_awvalid <= 1'b1;
              axi_wvalid  <= 1'b1;
              state       <= WR_ADDR;
            end else begin
              axi_araddr  <= addr[grant_idx*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
              axi_arvalid <= 1'b1;
              state       <= RD_ADDR;
            end
          end
        end
        WR_ADDR: begin
          // AW and W complete independently; move on once neither is still pending.
          if (axi_awready) axi_awvalid <= 1'b0;
          if (axi_wready)  axi_wvalid  <= 1'b0;
          if ((!axi_awvalid || axi_awready) && (!axi_wvalid || axi_wready)) begin
            axi_bready <= 1'b1;
            state      <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (axi_bvalid) begin
            err         <= axi_bresp[1];
            axi_bready  <= 1'b0;
            done[owner] <= 1'b1;
            state       <= DONE;
          end
        end
        RD_ADDR: begin
          if (axi_arready) begin
            axi_arvalid <= 1'b0;
            axi_rready  <= 1'b1;
            state       <= RD_RESP;
          end
        end
        RD_RESP: begin
          if (axi_rvalid) begin
            rdata       <= axi_rdata;
            err         <= axi_rresp[1];
            axi_rready  <= 1'b0;
            done[owner] <= 1'b1;
            state       <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_master_arb.sv
// Randomized bench for axi_lite_master_arb: random requesters and a random-latency AXI slave,
// checked against a transaction-level model of round-robin order, handshakes and completions.
module tb_axi_lite_master_arb;

  localparam int N       = 3;
  localparam int DW      = 32;
  localparam int AW      = 4;
  localparam int SW      = DW / 8;
  localparam int MAX_CYC = 3600;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic [N-1:0]  req, we, done;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata;
  logic [N*SW-1:0] wstrb;
  logic [DW-1:0] rdata;
  logic          err;
  logic [AW-1:0] axi_awaddr, axi_araddr;
  logic          axi_awvalid, axi_awready, axi_wvalid, axi_wready;
  logic          axi_bvalid, axi_bready, axi_arvalid, axi_arready, axi_rvalid, axi_rready;
  logic [2:0]    axi_awprot, axi_arprot;
  logic [DW-1:0] axi_wdata, axi_rdata;
  logic [SW-1:0] axi_wstrb;
  logic [1:0]    axi_bresp, axi_rresp;

  axi_lite_master_arb #(.NUM_REQ(N), .AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata), .wstrb(wstrb),
    .done(done), .rdata(rdata), .err(err),
    .axi_awaddr(axi_awaddr), .axi_awvalid(axi_awvalid), .axi_awprot(axi_awprot),
    .axi_awready(axi_awready), .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_bresp(axi_bresp),
    .axi_bvalid(axi_bvalid), .axi_bready(axi_bready), .axi_araddr(axi_araddr),
    .axi_arvalid(axi_arvalid), .axi_arprot(axi_arprot), .axi_arready(axi_arready),
    .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid),
    .axi_rready(axi_rready)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Requester-side transactions
  bit            r_act[N];
  bit            r_we[N];
  logic [AW-1:0] r_addr[N];
  logic [DW-1:0] r_wdata[N];
  logic [SW-1:0] r_wstrb[N];

  task automatic new_txn(input int i);
    r_act[i]   = 1'b1;
    r_we[i]    = 1'($urandom_range(0, 1));
    r_addr[i]  = AW'($urandom);
    r_wdata[i] = $urandom;
    r_wstrb[i] = SW'($urandom);
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < N; i++) begin
      req[i]             = r_act[i];
      we[i]              = r_we[i];
      addr[i*AW +: AW]   = r_addr[i];
      wdata[i*DW +: DW]  = r_wdata[i];
      wstrb[i*SW +: SW]  = r_wstrb[i];
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input int rr);
    for (int k = 0; k < N; k++)
      if (r[(rr + k) % N]) return (rr + k) % N;
    return -1;
  endfunction

  // Transaction-level reference model
  bit            m_busy, m_we, m_err;
  int            m_rr, m_owner;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;
  logic [SW-1:0] m_wstrb;
  bit            aw_got, w_got, ar_got, resp_seen, zero_wait, post_rst, abort;
  int            aw_cnt, w_cnt, ar_cnt, lat, busy_cyc, b_wait, r_wait, rdy_pct, n_inject;

  // Values driven or observed at the previous negedge, i.e. what the last posedge saw
  bit            p_reset, p_aw_hs, p_w_hs, p_ar_hs, p_b_hs, p_r_hs, p_done_cycle;
  bit            p_awvalid, p_wvalid, p_arvalid;
  logic [AW-1:0] p_awaddr, p_araddr;
  logic [DW-1:0] p_wdata, p_rdata;
  logic [SW-1:0] p_wstrb;
  logic [1:0]    p_bresp, p_rresp;

  initial begin
    bit done_now, new_grant, inject;
    reset = 1'b1;
    {axi_awready, axi_wready, axi_arready, axi_bvalid, axi_rvalid} = '0;
    axi_bresp = '0; axi_rresp = '0; axi_rdata = '0;
    for (int i = 0; i < N; i++) r_act[i] = 1'b0;
    drive_reqs();
    p_reset = 1'b1;
    {p_aw_hs, p_w_hs, p_ar_hs, p_b_hs, p_r_hs, p_done_cycle} = '0;
    {p_awvalid, p_wvalid, p_arvalid} = '0;
    m_busy = 1'b0; abort = 1'b0; n_inject = 0; busy_cyc = 0;

    for (int cyc = 0; cyc < MAX_CYC && !abort; cyc++) begin
      @(negedge clk);
      rdy_pct = (cyc < 1000) ? 100 : (cyc < 2000) ? 50 : (cyc < 3000) ? 25 : 60;
      done_now = 1'b0;
      new_grant = 1'b0;

      if (p_reset) begin
        check("rst_valid_ready", {axi_awvalid, axi_wvalid, axi_arvalid, axi_bready, axi_rready}, 0);
        check("rst_done", done, 0);
        check("rst_addr", {axi_awaddr, axi_araddr}, 0);
        check("rst_wdata", {axi_wstrb, axi_wdata}, 0);
        check("rst_rdata_err", {err, rdata}, 0);
        m_busy = 1'b0; m_rr = 0; m_rdata = '0; m_err = 1'b0; post_rst = 1'b1;
        {aw_got, w_got, ar_got, resp_seen} = '0;
        for (int i = 0; i < N; i++) r_act[i] = 1'b0;
        new_txn(0);
        new_txn(1);
      end else begin
        if (p_aw_hs || p_w_hs || p_ar_hs || p_b_hs || p_r_hs) check("hs_while_busy", m_busy, 1);
        if (p_aw_hs) begin check("aw_addr", p_awaddr, m_addr); aw_cnt++; aw_got = 1'b1; end
        if (p_w_hs)  begin check("w_data", {p_wstrb, p_wdata}, {m_wstrb, m_wdata}); w_cnt++; w_got = 1'b1; end
        if (p_ar_hs) begin check("ar_addr", p_araddr, m_addr); ar_cnt++; ar_got = 1'b1; end
        if (p_b_hs) begin
          check("aw_w_count", {aw_cnt, w_cnt}, {32'd1, 32'd1});
          m_err = p_bresp[1]; resp_seen = 1'b1; done_now = 1'b1;
        end
        if (p_r_hs) begin
          check("ar_count", ar_cnt, 1);
          m_rdata = p_rdata; m_err = p_rresp[1]; resp_seen = 1'b1; done_now = 1'b1;
        end

        if (m_busy && p_done_cycle) begin
          m_busy = 1'b0;
        end else if (!m_busy && req != '0) begin
          m_owner = pick(req, m_rr);
          m_rr    = (m_owner + 1) % N;
          m_busy  = 1'b1; new_grant = 1'b1;
          m_we = r_we[m_owner]; m_addr = r_addr[m_owner];
          m_wdata = r_wdata[m_owner]; m_wstrb = r_wstrb[m_owner];
          {aw_got, w_got, ar_got, resp_seen} = '0;
          aw_cnt = 0; w_cnt = 0; ar_cnt = 0; lat = 0;
          zero_wait = (rdy_pct == 100);
          b_wait = zero_wait ? 0 : $urandom_range(0, 3);
          r_wait = zero_wait ? 0 : $urandom_range(0, 3);
          if (post_rst) begin check("first_grant_after_reset", m_owner, 0); post_rst = 1'b0; end
        end else if (m_busy) begin
          lat++;
        end

        check("valids", {axi_awvalid, axi_wvalid, axi_arvalid},
              {m_busy && m_we && !aw_got, m_busy && m_we && !w_got, m_busy && !m_we && !ar_got});
        if (p_awvalid && axi_awvalid) check("aw_stable", axi_awaddr, p_awaddr);
        if (p_wvalid && axi_wvalid)   check("w_stable", {axi_wstrb, axi_wdata}, {p_wstrb, p_wdata});
        if (p_arvalid && axi_arvalid) check("ar_stable", axi_araddr, p_araddr);
        check("bready", axi_bready, m_busy && m_we && aw_got && w_got && !resp_seen);
        check("rready", axi_rready, m_busy && !m_we && ar_got && !resp_seen);
        check("done", done, done_now ? (64'd1 << m_owner) : 64'd0);
        check("rdata", rdata, m_rdata);
        check("err", err, m_err);
        check("prot", {axi_awprot, axi_arprot}, 0);
        if (done_now && zero_wait) check("min_latency", lat, 2);

        busy_cyc = m_busy ? busy_cyc + 1 : 0;
        if (busy_cyc > 200) begin
          check("txn_timeout", busy_cyc, 200);
          abort = 1'b1;
        end

        // Requesters: drop or re-raise on done, occasionally start new work
        for (int i = 0; i < N; i++) begin
          if (done[i]) begin
            if ($urandom_range(0, 2) == 0) new_txn(i);
            else r_act[i] = 1'b0;
          end else if (!r_act[i] && $urandom_range(0, 3) == 0) begin
            new_txn(i);
          end
        end
        // Once latched, the owner's fields may change without affecting the transaction
        if (new_grant) begin
          r_we[m_owner] = 1'($urandom_range(0, 1));
          r_addr[m_owner] = AW'($urandom);
          r_wdata[m_owner] = $urandom;
          r_wstrb[m_owner] = SW'($urandom);
        end
      end

      inject = 1'b0;
      if (!p_reset && axi_bready &&
          ((cyc >= 3000 && n_inject == 0) || (cyc >= 3300 && n_inject == 1))) begin
        inject = 1'b1;
        n_inject++;
      end
      reset = (cyc < 2) || inject;

      // Slave
      if (reset) begin
        {axi_awready, axi_wready, axi_arready, axi_bvalid, axi_rvalid} = '0;
      end else begin
        axi_awready = ($urandom_range(0, 99) < rdy_pct);
        axi_wready  = ($urandom_range(0, 99) < rdy_pct);
        axi_arready = ($urandom_range(0, 99) < rdy_pct);
        if (p_b_hs) axi_bvalid = 1'b0;
        if (p_r_hs) axi_rvalid = 1'b0;
        if (!axi_bvalid && m_busy && m_we && aw_got && w_got && !resp_seen) begin
          if (b_wait == 0) begin axi_bvalid = 1'b1; axi_bresp = 2'($urandom); end
          else b_wait--;
        end
        if (!axi_rvalid && m_busy && !m_we && ar_got && !resp_seen) begin
          if (r_wait == 0) begin axi_rvalid = 1'b1; axi_rdata = $urandom; axi_rresp = 2'($urandom); end
          else r_wait--;
        end
      end

      p_reset      = reset;
      p_aw_hs      = !reset && axi_awvalid && axi_awready;
      p_w_hs       = !reset && axi_wvalid && axi_wready;
      p_ar_hs      = !reset && axi_arvalid && axi_arready;
      p_b_hs       = !reset && axi_bvalid && axi_bready;
      p_r_hs       = !reset && axi_rvalid && axi_rready;
      p_awvalid    = axi_awvalid;
      p_wvalid     = axi_wvalid;
      p_arvalid    = axi_arvalid;
      p_awaddr     = axi_awaddr;
      p_araddr     = axi_araddr;
      p_wdata      = axi_wdata;
      p_wstrb      = axi_wstrb;
      p_bresp      = axi_bresp;
      p_rdata      = axi_rdata;
      p_rresp      = axi_rresp;
      p_done_cycle = done_now;
      drive_reqs();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
